pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline. It generates the per-latch enable (`*_ena`) and squash (`*_x`) strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves three hazard classes:
- load-use data hazards, by inserting a one-cycle bubble;
- branch mispredictions, by a multi-cycle wrong-path squash;
- data-memory wait states, by a full pipeline freeze.

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// ---------------------------------------------------------------------------
// Central stall/flush controller for the 5-stage pipeline. Drives the latch
// enables (*_ena) and squash strobes (*_x) for the IF/ID (fl), ID/EX (dl),
// EX/MEM (el) and MEM/WB (ml) latches. It resolves three hazard classes:
//   - load-use: a one-cycle bubble into ID/EX while IF/ID holds;
//   - branch mispredict: IF/ID is squashed for FLUSH_DEPTH cycles, and ID/EX
//     is squashed in the resolving cycle;
//   - data-memory wait: a full freeze of all four latches.
//
// Parameters:
//   FLUSH_DEPTH  total squash cycles on IF/ID after a mispredict (1..7)
//   CNT_W        performance counter width
//
// Ports:
//   stg_clk, reset                  clock, async active-high reset
//   dec_*                           ID stage operand usage
//   ex_*                            EX stage destination / load info
//   br_resolve, br_mispredict       branch outcome from EX
//   mem_req, mem_ready              MEM stage handshake
//   fl/dl/el/ml_ena, fl_x, dl_x     latch enables and squashes (combinational)
//   state                           0=RUN, 1=FLUSH, 2=MEM_WAIT
//   stall_cnt, flush_cnt            saturating performance counters
//
// Configuration macro: HAZARD_PERF_CNT_EN enables the performance counters;
// when it is undefined both counter ports are tied to zero.

module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_save_to_reg,
  input  logic             ex_rd_memory,
  input  logic             br_resolve,
  input  logic             br_mispredict,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             fl_ena,
  output logic             dl_ena,
  output logic             el_ena,
  output logic             ml_ena,
  output logic             fl_x,
  output logic             dl_x,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  // Cycles left in FLUSH after the resolving cycle.
  localparam logic [2:0] FlushInit = 3'(FLUSH_DEPTH - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic memstall, loaduse, mispred;
  logic rs1_hit, rs2_hit;

  assign memstall = mem_req & ~mem_ready;
  assign mispred  = br_resolve & br_mispredict;
  assign rs1_hit  = dec_rs1_used & (dec_rs1 == ex_rd);
  assign rs2_hit  = dec_rs2_used & (dec_rs2 == ex_rd);
  assign loaduse  = ex_valid & ex_rd_memory & ex_save_to_reg & (ex_rd != 5'd0) &
                    dec_valid & (rs1_hit | rs2_hit);

  always_comb begin
    fl_ena  = 1'b1;
    dl_ena  = 1'b1;
    el_ena  = 1'b1;
    ml_ena  = 1'b1;
    fl_x    = 1'b0;
    dl_x    = 1'b0;
    state_d = state_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      // MEM_WAIT behaves exactly like RUN once memory releases.
      StRun, StMemWait: begin
        if (memstall) begin
          {fl_ena, dl_ena, el_ena, ml_ena} = 4'b0000;
          state_d = StMemWait;
        end else if (mispred) begin
          fl_x = 1'b1;
          dl_x = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = StFlush;
            fcnt_d  = FlushInit;
          end else begin
            state_d = StRun;
            fcnt_d  = 3'd0;
          end
        end else if (loaduse) begin
          // Hold the dependent instruction in ID, push a bubble into EX.
          fl_ena  = 1'b0;
          dl_x    = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StRun;
        end
      end
      // EX and ID hold squashed slots here, so branch and load-use are moot.
      StFlush: begin
        if (memstall) begin
          {fl_ena, dl_ena, el_ena, ml_ena} = 4'b0000;
        end else begin
          fl_x = 1'b1;
          if (fcnt_q <= 3'd1) begin
            state_d = StRun;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = 3'd0;
      end
    endcase

    // Reset forces a full freeze with no squash regardless of state.
    if (reset) begin
      {fl_ena, dl_ena, el_ena, ml_ena} = 4'b0000;
      fl_x = 1'b0;
      dl_x = 1'b0;
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters; reset already forces fl_ena low and fl_x low.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!fl_ena && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (fl_x && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
